wm8731_dac_serializer: RTL and testbench
========================================

# wm8731_dac_serializer

Converts 32-bit stereo samples, written by the master-bus register block, into the WM8731 DAC serial stream (BCLK, DACLRC, DACDAT) in I2S format with the codec in slave mode. It sits directly downstream of the DAC audio register (`ADDR_DAC_AUDIO`) in the codec top, and upstream of the board pins and the DAC functional model. It provides a one-entry holding buffer with a valid/ready handshake, so the bus can write the next sample while the current one is still shifting out.

## Interface
Parameters:
- CLK_DIV, 16: `clk` cycles per BCLK half-period (≥2); BCLK = f_clk/(2·CLK_DIV).
- SLOT, 32: BCLK periods per channel slot (≥17); frame = 2·SLOT BCLKs.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  32  sample; left channel = [31:16], right channel = [15:0], two's complement.
- s_valid  in  1  sample offered.
- s_ready  out  1  holding register can accept a sample.
- bclk_o  out  1  bit clock to the codec.
- daclrc_o  out  1  0 = left slot, 1 = right slot.
- dacdat_o  out  1  serial data to the codec; changes on BCLK falling edges.
- frame_start  out  1  one-cycle pulse when a new frame loads.
- underrun  out  1  one-cycle pulse when a frame starts with the holding register empty.

## Operation
- **Divider.** `div_cnt` counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and `bclk_o` toggles. A 1→0 toggle is the "fall" event.
- **Bit counter.** `bit_cnt` counts 0..2·SLOT-1 and advances on each fall, wrapping to 0.
  - Its reset value is 2·SLOT-1, so the first fall after reset starts a frame at `bit_cnt`=0.
  - `daclrc_o` = (`bit_cnt` ≥ SLOT), registered on the fall.
- **Frame load.** On the fall where `bit_cnt` wraps to 0 (load cycle), `frame_start` pulses.
  - If the holding register is valid: the shifter loads it, the holding register becomes empty, and `last` is set to that sample.
  - If the holding register is empty: the shifter loads `last` (repeat the previous sample) and `underrun` pulses.
- **Handshake.** `s_ready` = ~hold_valid. A transfer occurs on a clk edge where `s_valid` and `s_ready` are both 1; the holding register captures `s_data`.
- **Write during an empty load cycle.** If a write arrives in the same cycle as a load with the holding register empty, the load uses `last` and `underrun` pulses. The written sample is kept in the holding register for the next frame.
- **Data slot mapping.** With k = `bit_cnt` mod SLOT, channel c = left when `bit_cnt` < SLOT, else right:
  - k=0: 0 (I2S one-BCLK delay).
  - k=1..16: bit 16-k of channel c (MSB first).
  - k≥17: 0.
- **Reset.** Reset mid-frame aborts immediately. All state returns to reset values, and the next frame restarts cleanly after the first fall.

## Timing
- Reset values:
  - Outputs: `bclk_o`=0, `daclrc_o`=0, `dacdat_o`=0, `s_ready`=1, `frame_start`=0, `underrun`=0.
  - Internal state: `div_cnt`=0, `bit_cnt`=2·SLOT-1, hold_valid=0, hold=0, `last`=0, shifter=0.
- First fall occurs 2·CLK_DIV clk cycles after reset deasserts. That first frame always underruns unless a sample was written before it.
- Timing at the defaults:
  - Sample rate = 50 MHz/(2·16·64) = 24.414 kHz.
  - Frame = 2048 clk cycles.
- Latency: a left-channel MSB appears on `dacdat_o` one BCLK period (2·CLK_DIV clk) after `frame_start`. The right-channel MSB appears SLOT BCLKs after that.
- All outputs are registered; there are no combinational paths from `s_*` to the pins.
- `s_ready` rises in the clk cycle after a load empties the holding register.

## Structure
- Shared package `codec_pkg`:
  - Constants `CH_BITS`=16 and `SAMPLE_W`=32.
  - Default CLK_DIV and SLOT.
  - The `ADDR_DAC_AUDIO` constant already used by the bus map.
- Sub-module `wm8731_bclk_gen`:
  - Divider plus bit counter.
  - Outputs `bclk_o`, `daclrc_o`, a fall strobe and `bit_cnt`.
  - Reused later by the ADC deserializer for ADCLRC.
- The top level holds the holding register, `last`, the shifter and the pulse outputs. Target size is about 150–250 lines total.

## Test plan
- **Reset check.** Hold `rst` for 10 cycles, then release → all outputs at reset values. The first `frame_start` arrives 32 cycles after release with `underrun`=1, and `dacdat_o` stays 0 for the whole frame.
- **Single sample.** Write 32'h24842129 before the first frame → in that frame, the left slot bits k=1..16 are 0x2484 and the right slot bits are 0x2129. `daclrc_o` toggles every 1024 clk. `underrun`=0.
- **Back-to-back writes.** Write 32'h24842128 then 32'h24842127 → the second write stalls (`s_ready`=0) until the next `frame_start`. Frames carry 0x2484/0x2128, then 0x2484/0x2127, in order with none lost.
- **Underrun repeat.** Write 32'h24842126, then none → the following frame repeats 0x2484/0x2126 and `underrun` pulses once per empty frame.
- **Write on an empty load cycle.** Assert `s_valid` with 32'h24842125 exactly on a load cycle while empty → `underrun` pulses and the old sample repeats. 0x2125 is sent in the next frame.
- **Reset mid-frame.** Assert `rst` mid-right-slot, then write 32'h24842123 → outputs return to reset immediately. The first frame after release carries 0x2484/0x2123, and `dacfm.dacread` reports a match.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared constants for the WM8731 codec blocks: sample geometry, default
// serial timing and the bus address of the DAC audio register.
package codec_pkg;

  localparam int CH_BITS  = 16;
  localparam int SAMPLE_W = 2 * CH_BITS;

  localparam int DEFAULT_CLK_DIV = 16;
  localparam int DEFAULT_SLOT    = 32;

  localparam logic [7:0] ADDR_DAC_AUDIO = 8'h0C;

  typedef struct packed {
    logic signed [CH_BITS-1:0] left;
    logic signed [CH_BITS-1:0] right;
  } stereoSample_t;

  // Ceiling log2 that never returns 0, so counters are always at least 1 bit.
  function automatic int cntWidth(input int states);
    return (states <= 2) ? 1 : $clog2(states);
  endfunction

endpackage

// File: rtl/wm8731_bclk_gen.sv
// BCLK / LRCLK generator: clk divider, bit counter across a 2*SLOT frame and
// a one-cycle strobe on every BCLK falling edge. Shared with the ADC path.
module wm8731_bclk_gen
  import codec_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int SLOT    = DEFAULT_SLOT,
  parameter int BIT_W   = cntWidth(2 * SLOT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             bclk_o,
  output logic             daclrc_o,
  output logic             fall,
  output logic [BIT_W-1:0] bit_cnt
);

  localparam int DIV_W = cntWidth(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT - 1);
  localparam logic [BIT_W-1:0] RIGHT_SLOT = BIT_W'(SLOT);

  logic [DIV_W-1:0] divCnt;
  logic             divWrap;
  logic [BIT_W-1:0] bitNext;

  assign divWrap = (divCnt == DIV_LAST);
  // A wrap while BCLK is high is the 1->0 toggle.
  assign fall    = divWrap & bclk_o;
  assign bitNext = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt   <= '0;
      bclk_o   <= 1'b0;
      bit_cnt  <= BIT_LAST;
      daclrc_o <= 1'b0;
    end else begin
      if (divWrap) begin
        divCnt <= '0;
        bclk_o <= ~bclk_o;
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end

      if (fall) begin
        bit_cnt  <= bitNext;
        daclrc_o <= (bitNext >= RIGHT_SLOT);
      end
    end
  end

endmodule

// File: rtl/wm8731_dac_serializer.sv
// I2S serializer for the WM8731 DAC in slave mode: one-entry holding register
// with valid/ready, frame shifter and repeat-last-sample on underrun.
module wm8731_dac_serializer
  import codec_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int SLOT    = DEFAULT_SLOT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                bclk_o,
  output logic                daclrc_o,
  output logic                dacdat_o,
  output logic                frame_start,
  output logic                underrun
);

  localparam int BIT_W = cntWidth(2 * SLOT);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT - 1);
  localparam logic [BIT_W-1:0] RIGHT_SLOT = BIT_W'(SLOT);
  localparam logic [BIT_W-1:0] FIRST_DATA = BIT_W'(1);
  localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(CH_BITS);

  logic             bclkFall;
  logic [BIT_W-1:0] bitCnt;

  wm8731_bclk_gen #(
    .CLK_DIV (CLK_DIV),
    .SLOT    (SLOT),
    .BIT_W   (BIT_W)
  ) bclkGen (
    .clk      (clk),
    .rst      (rst),
    .bclk_o   (bclk_o),
    .daclrc_o (daclrc_o),
    .fall     (bclkFall),
    .bit_cnt  (bitCnt)
  );

  logic                holdValid;
  stereoSample_t       holdReg;
  stereoSample_t       lastReg;
  logic [SAMPLE_W-1:0] shifterReg;

  logic                loadCycle;
  logic                accept;
  stereoSample_t       loadValue;
  logic [BIT_W-1:0]    bitNext;
  logic [BIT_W-1:0]    slotPos;
  logic                dataBit;

  assign s_ready   = ~holdValid;
  assign accept    = s_valid & ~holdValid;
  assign loadCycle = bclkFall & (bitCnt == BIT_LAST);
  assign loadValue = holdValid ? holdReg : lastReg;

  // Position within the channel slot that the upcoming fall moves to.
  always_comb begin
    bitNext = '0;
    slotPos = '0;
    dataBit = 1'b0;
    if (!loadCycle) begin
      bitNext = bitCnt + BIT_W'(1);
    end
    slotPos = (bitNext >= RIGHT_SLOT) ? bitNext - RIGHT_SLOT : bitNext;
    dataBit = (slotPos >= FIRST_DATA) && (slotPos <= LAST_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdValid   <= 1'b0;
      holdReg     <= '0;
      lastReg     <= '0;
      shifterReg  <= '0;
      dacdat_o    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= loadCycle;
      underrun    <= loadCycle & ~holdValid;

      // A write is only accepted while empty, so it never collides with a
      // load that drains the holding register; an empty load keeps the write.
      if (accept) begin
        holdReg   <= stereoSample_t'(s_data);
        holdValid <= 1'b1;
      end else if (loadCycle) begin
        holdValid <= 1'b0;
      end

      if (loadCycle) begin
        shifterReg <= loadValue;
        lastReg    <= loadValue;
        dacdat_o   <= 1'b0;
      end else if (bclkFall) begin
        // After 16 left-channel shifts the right channel sits in the MSBs.
        if (dataBit) begin
          dacdat_o   <= shifterReg[SAMPLE_W-1];
          shifterReg <= {shifterReg[SAMPLE_W-2:0], 1'b0};
        end else begin
          dacdat_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wm8731_dac_serializer.sv
// Self-checking bench for wm8731_dac_serializer: a cycle-count model of the
// holding register predicts every frame's content and underrun flag.
module tb_wm8731_dac_serializer;

  localparam int CLK_DIV    = 16;
  localparam int SLOT       = 32;
  localparam int BCLK_CYC   = 2 * CLK_DIV;
  localparam int FRAME_CYC  = 2 * SLOT * BCLK_CYC;
  localparam int FIRST_FALL = BCLK_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        bclk_o;
  logic        daclrc_o;
  logic        dacdat_o;
  logic        frame_start;
  logic        underrun;

  int nChecks = 0;
  int nFails  = 0;

  wm8731_dac_serializer #(
    .CLK_DIV (CLK_DIV),
    .SLOT    (SLOT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .bclk_o      (bclk_o),
    .daclrc_o    (daclrc_o),
    .dacdat_o    (dacdat_o),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #10 clk = ~clk;

  // Reference model: loads happen every FRAME_CYC clocks starting FIRST_FALL
  // clocks after reset release; each load takes the held sample or repeats.
  int          mCycle;
  logic        mHoldValid;
  logic [31:0] mHold;
  logic [31:0] mLast;
  logic [31:0] mFrameData;
  logic        mFrameUnder;

  function automatic bit is_load_edge(input int n);
    return (n >= FIRST_FALL) && (((n - FIRST_FALL) % FRAME_CYC) == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCycle      <= 0;
      mHoldValid  <= 1'b0;
      mHold       <= '0;
      mLast       <= '0;
      mFrameData  <= '0;
      mFrameUnder <= 1'b0;
    end else begin
      mCycle <= mCycle + 1;
      if (is_load_edge(mCycle + 1)) begin
        if (mHoldValid) begin
          mFrameData  <= mHold;
          mFrameUnder <= 1'b0;
          mLast       <= mHold;
          mHoldValid  <= 1'b0;
        end else begin
          mFrameData  <= mLast;
          mFrameUnder <= 1'b1;
        end
      end
      if (s_valid === 1'b1 && !mHoldValid) begin
        mHold      <= s_data;
        mHoldValid <= 1'b1;
      end
    end
  end

  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] d, output int stalls);
    logic acc;
    stalls = 0;
    acc = 1'b0;
    @(negedge clk);
    s_data = d;
    s_valid = 1'b1;
    for (int i = 0; i < 5000 && !acc; i++) begin
      nChecks++;
      if (s_ready !== !mHoldValid) begin
        nFails++;
        $display("FAIL s_ready: got %b, required %b", s_ready, !mHoldValid);
      end
      if (mHoldValid) stalls++;
      else acc = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    nChecks++;
    if (!acc) begin
      nFails++;
      $display("FAIL write_accept: sample %h not accepted, required acceptance", d);
    end
    $display("write  data=%h stalls=%0d", d, stalls);
  endtask

  task automatic check_frame(input string tag, output int waited);
    logic [63:0] bits;
    logic [63:0] lrc;
    logic [63:0] expLrc;
    logic [63:0] dataMask;
    logic [15:0] gotL;
    logic [15:0] gotR;
    logic [31:0] expD;
    logic        expU;
    logic        prevB;
    logic        found;
    int          cyc;
    int          j;
    bits = '0;
    lrc = '0;
    waited = 0;
    found = 1'b0;
    while (!found && waited < 2 * FRAME_CYC + 100) begin
      @(negedge clk);
      waited++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    nChecks++;
    if (!found) begin
      nFails++;
      $display("FAIL %s frame_start: got none in %0d cycles, required a pulse", tag, waited);
      return;
    end
    expD = mFrameData;
    expU = mFrameUnder;
    nChecks++;
    if (underrun !== expU) begin
      nFails++;
      $display("FAIL %s underrun: got %b, required %b", tag, underrun, expU);
    end
    prevB = bclk_o;
    cyc = 0;
    j = 0;
    while (j < 64 && cyc < FRAME_CYC + 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        nChecks++;
        if (frame_start !== 1'b0 || underrun !== 1'b0) begin
          nFails++;
          $display("FAIL %s pulse_width: got fs=%b ur=%b, required 0 0", tag, frame_start, underrun);
        end
      end
      if (prevB === 1'b0 && bclk_o === 1'b1) begin
        bits[j] = dacdat_o;
        lrc[j]  = daclrc_o;
        j++;
      end
      prevB = bclk_o;
    end
    nChecks++;
    if (j != 64 || cyc != BCLK_CYC / 2 + 63 * BCLK_CYC) begin
      nFails++;
      $display("FAIL %s bclk_timing: got %0d edges in %0d cycles, required 64 in %0d",
               tag, j, cyc, BCLK_CYC / 2 + 63 * BCLK_CYC);
    end
    dataMask = '0;
    for (int i = 0; i < 16; i++) begin
      gotL[15 - i] = bits[1 + i];
      gotR[15 - i] = bits[SLOT + 1 + i];
      dataMask[1 + i] = 1'b1;
      dataMask[SLOT + 1 + i] = 1'b1;
    end
    expLrc = {{32{1'b1}}, {32{1'b0}}};
    nChecks++;
    if (gotL !== expD[31:16]) begin
      nFails++;
      $display("FAIL %s left: got %h, required %h", tag, gotL, expD[31:16]);
    end
    nChecks++;
    if (gotR !== expD[15:0]) begin
      nFails++;
      $display("FAIL %s right: got %h, required %h", tag, gotR, expD[15:0]);
    end
    nChecks++;
    if ((bits & ~dataMask) !== 64'd0) begin
      nFails++;
      $display("FAIL %s pad_bits: got %h, required 0", tag, bits & ~dataMask);
    end
    nChecks++;
    if (lrc !== expLrc) begin
      nFails++;
      $display("FAIL %s daclrc: got %h, required %h", tag, lrc, expLrc);
    end
    $display("frame  %s L=%h R=%h underrun=%b", tag, gotL, gotR, expU);
  endtask

  task automatic test_reset();
    int w;
    pulse_reset(10);
    rst = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({bclk_o, daclrc_o, dacdat_o, s_ready, frame_start, underrun} !== 6'b000100) begin
      nFails++;
      $display("FAIL reset_hold: got %b, required 000100",
               {bclk_o, daclrc_o, dacdat_o, s_ready, frame_start, underrun});
    end
    rst = 1'b0;
    #1;
    nChecks++;
    if ({bclk_o, daclrc_o, dacdat_o, s_ready, frame_start, underrun} !== 6'b000100) begin
      nFails++;
      $display("FAIL reset_release: got %b, required 000100",
               {bclk_o, daclrc_o, dacdat_o, s_ready, frame_start, underrun});
    end
    check_frame("reset_first", w);
    nChecks++;
    if (w != FIRST_FALL) begin
      nFails++;
      $display("FAIL first_frame_latency: got %0d, required %0d", w, FIRST_FALL);
    end
  endtask

  task automatic test_single();
    int st;
    int w;
    pulse_reset(4);
    do_write(32'h24842129, st);
    check_frame("single", w);
  endtask

  task automatic test_back_to_back();
    int stA;
    int stB;
    int w0;
    int w1;
    fork
      begin
        do_write(32'h24842128, stA);
        do_write(32'h24842127, stB);
      end
      begin
        check_frame("b2b_first", w0);
        check_frame("b2b_second", w1);
      end
    join
    nChecks++;
    if (stB < 1) begin
      nFails++;
      $display("FAIL b2b_stall: got %0d stall cycles, required at least 1", stB);
    end
  endtask

  task automatic test_underrun_repeat();
    int st;
    int w;
    fork
      do_write(32'h24842126, st);
      begin
        check_frame("urun_load", w);
        check_frame("urun_rep1", w);
        check_frame("urun_rep2", w);
      end
    join
  endtask

  task automatic test_empty_load_write();
    int w;
    logic hit;
    fork
      begin
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC && !hit; i++) begin
          @(negedge clk);
          if (is_load_edge(mCycle + 1)) hit = 1'b1;
        end
        nChecks++;
        if (!hit || s_ready !== 1'b1) begin
          nFails++;
          $display("FAIL empty_load_ready: got hit=%b s_ready=%b, required 1 1", hit, s_ready);
        end
        s_data = 32'h24842125;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        nChecks++;
        if (s_ready !== 1'b0) begin
          nFails++;
          $display("FAIL empty_load_held: got s_ready=%b, required 0", s_ready);
        end
        $display("write  data=%h on load cycle", 32'h24842125);
      end
      begin
        check_frame("eload_repeat", w);
        check_frame("eload_next", w);
      end
    join
  endtask

  task automatic test_random();
    int st;
    int w;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          repeat ($urandom_range(0, 2500)) @(negedge clk);
          do_write($urandom, st);
        end
      end
      begin
        for (int f = 0; f < 6; f++) check_frame("random", w);
      end
    join
  endtask

  task automatic test_reset_mid();
    int st;
    int w;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC && !found; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
    end
    repeat (SLOT * BCLK_CYC + 400) @(negedge clk);
    rst = 1'b1;
    #1;
    nChecks++;
    if (!found || {bclk_o, daclrc_o, dacdat_o, s_ready, frame_start, underrun} !== 6'b000100) begin
      nFails++;
      $display("FAIL reset_mid: got found=%b outs=%b, required 1 000100", found,
               {bclk_o, daclrc_o, dacdat_o, s_ready, frame_start, underrun});
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    do_write(32'h24842123, st);
    check_frame("after_reset", w);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun_repeat();
    test_empty_load_write();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
